// File: rtl/card_cmd_sequencer_if.sv
// card_cmd_sequencer_if: UART byte stream, response byte and card-driver request signals
interface card_cmd_sequencer_if;
    logic        RX_STB;
    logic [7:0]  RX_DAT;
    logic        TX_STB;
    logic [7:0]  TX_DAT;
    logic        TX_ACK;
    logic        WR_STB;
    logic [31:0] WR_ADDR;
    logic [31:0] WR_LENGTH;
    logic        WR_ACK;
    logic        RD_STB;
    logic [31:0] RD_ADDR;
    logic [31:0] RD_LENGTH;
    logic        RD_ACK;
    logic        DRV_BUSY;
    logic        CMD_ACTIVE;
    modport master (
        input  RX_STB, RX_DAT, TX_ACK, WR_ACK, RD_ACK, DRV_BUSY,
        output TX_STB, TX_DAT, WR_STB, WR_ADDR, WR_LENGTH, RD_STB, RD_ADDR, RD_LENGTH, CMD_ACTIVE
    );
    modport slave (
        output RX_STB, RX_DAT, TX_ACK, WR_ACK, RD_ACK, DRV_BUSY,
        input  TX_STB, TX_DAT, WR_STB, WR_ADDR, WR_LENGTH, RD_STB, RD_ADDR, RD_LENGTH, CMD_ACTIVE
    );
endinterface

// File: rtl/card_cmd_sequencer.sv
// card_cmd_sequencer: parses 9-byte UART command frames into card-driver read/write requests and answers K/E/T
module card_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 5000000,
    parameter logic [31:0] MAX_LENGTH  = 32'h00FFFFFF
) (
    input logic                  CLOCK50,
    input logic                  nRESET,
    card_cmd_sequencer_if.master bus
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [7:0] OP_W = 8'h77;
    localparam logic [7:0] OP_R = 8'h72;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_E = 8'h45;
    localparam logic [7:0] RSP_T = 8'h54;
    typedef enum logic [2:0] {IDLE, ADDR, LEN, CHECK, ISSUE, WAIT_START, WAIT_DONE, RESP} state_t;
    state_t          state, state_nxt;
    logic            is_wr;
    logic [31:0]     addr_sh, len_sh;
    logic [1:0]      byte_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [3:0]      start_cnt;
    logic            in_hdr, timeout, len_bad;
    assign in_hdr  = state == ADDR || state == LEN;
    // an arriving byte always beats a simultaneous expiry
    assign timeout = in_hdr && !bus.RX_STB && tmo_cnt == TW'(TIMEOUT_CYC - 1);
    assign len_bad = len_sh == '0 || len_sh > MAX_LENGTH;
    always_ff @(posedge CLOCK50 or negedge nRESET) begin
        if (!nRESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = bus.RX_STB && (bus.RX_DAT == OP_W || bus.RX_DAT == OP_R) ? ADDR : IDLE;
            ADDR:       state_nxt = timeout ? RESP : bus.RX_STB && byte_cnt == 2'd3 ? LEN : ADDR;
            LEN:        state_nxt = timeout ? RESP : bus.RX_STB && byte_cnt == 2'd3 ? CHECK : LEN;
            CHECK:      state_nxt = len_bad ? RESP : ISSUE;
            ISSUE:      state_nxt = (is_wr ? bus.WR_ACK : bus.RD_ACK) ? WAIT_START : ISSUE;
            // drivers may never raise BUSY on short transfers, so give up waiting after 16 cycles
            WAIT_START: state_nxt = bus.DRV_BUSY || start_cnt == 4'd15 ? WAIT_DONE : WAIT_START;
            WAIT_DONE:  state_nxt = bus.DRV_BUSY ? WAIT_DONE : RESP;
            RESP:       state_nxt = bus.TX_ACK ? IDLE : RESP;
            default:    state_nxt = IDLE;
        endcase
    end
    always_comb begin
        bus.WR_STB     = state == ISSUE && is_wr;
        bus.RD_STB     = state == ISSUE && !is_wr;
        bus.TX_STB     = state == RESP;
        bus.CMD_ACTIVE = state != IDLE;
    end
    always_ff @(posedge CLOCK50 or negedge nRESET) begin
        if (!nRESET) begin
            is_wr         <= 1'b0;
            addr_sh       <= '0;
            len_sh        <= '0;
            byte_cnt      <= '0;
            tmo_cnt       <= '0;
            start_cnt     <= '0;
            bus.TX_DAT    <= '0;
            bus.WR_ADDR   <= '0;
            bus.WR_LENGTH <= '0;
            bus.RD_ADDR   <= '0;
            bus.RD_LENGTH <= '0;
        end else begin
            if (state == IDLE) begin
                byte_cnt <= '0;
                tmo_cnt  <= '0;
                if (bus.RX_STB)
                    is_wr <= bus.RX_DAT == OP_W;
            end
            if (in_hdr) begin
                tmo_cnt <= bus.RX_STB ? '0 : tmo_cnt + 1'b1;
                if (bus.RX_STB) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (state == ADDR)
                        addr_sh <= {addr_sh[23:0], bus.RX_DAT};
                    else
                        len_sh <= {len_sh[23:0], bus.RX_DAT};
                end
            end
            start_cnt <= state == WAIT_START ? start_cnt + 4'd1 : 4'd0;
            if (state == CHECK && !len_bad) begin
                if (is_wr) begin
                    bus.WR_ADDR   <= addr_sh;
                    bus.WR_LENGTH <= len_sh;
                end else begin
                    bus.RD_ADDR   <= addr_sh;
                    bus.RD_LENGTH <= len_sh;
                end
            end
            if (state != RESP && state_nxt == RESP)
                bus.TX_DAT <= state == CHECK ? RSP_E : state == WAIT_DONE ? RSP_K : RSP_T;
        end
    end
endmodule
